// File: rtl/narrow_pkg.sv
// rtl/narrow_pkg.sv - shared constants and helpers for the signed narrowing unit
// Purpose: default widths, rounding-mode encodings, overflow counter width and
//          the saturation bound helpers used by imm_narrow8.
// Ports: none (package).
package narrow_pkg;

  localparam int IN_W_DEFAULT  = 8;
  localparam int OUT_W_DEFAULT = 4;

  // Value carried on sat_en alongside each word.
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int COUNT_W = 8;

  // Most negative OUT_W-bit two's-complement value, {1, 0...0}, zero-extended to 32 bits.
  function automatic logic [31:0] sat_min(input int outW);
    return 32'(1) << (outW - 1);
  endfunction

  // Most positive OUT_W-bit two's-complement value, {0, 1...1}, zero-extended to 32 bits.
  function automatic logic [31:0] sat_max(input int outW);
    return (32'(1) << (outW - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/narrow_stage.sv
// rtl/narrow_stage.sv - generic valid/ready register slice
// Purpose: one pipeline register with its own valid bit. It loads whenever it is
//          empty or its word is being taken downstream, so chained slices give
//          full throughput with no bubble.
// Ports:
//   clk, reset       clock, synchronous active-high reset (clears valid and data)
//   inValid/inReady  upstream handshake; inReady is combinational
//   inData           payload, W bits
//   outValid/outReady downstream handshake
//   outData          registered payload, held stable while outValid && !outReady
module narrow_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inValid,
  output logic         inReady,
  input  logic [W-1:0] inData,
  output logic         outValid,
  input  logic         outReady,
  output logic [W-1:0] outData
);

  assign inReady = !outValid || outReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      outValid <= 1'b0;
      outData  <= '0;
    end else if (inReady) begin
      outValid <= inValid;
      // Data only moves with a real word, so an idle slot keeps its last value.
      if (inValid) begin
        outData <= inData;
      end
    end
  end

endmodule

// File: rtl/imm_narrow8.sv
// rtl/imm_narrow8.sv - two-stage signed narrowing unit with overflow tracking
// Purpose: narrows IN_W-bit two's-complement words to OUT_W bits, saturating or
//          wrapping per word, flags non-representable inputs and keeps a sticky
//          overflow flag plus a saturating count of delivered overflows.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     input stream handshake (in_ready is combinational)
//   data_in, sat_en       source word and its mode (1 = saturate, 0 = wrap)
//   out_valid/out_ready   output stream handshake
//   data_out, ovf         narrowed word and its not-representable flag
//   ovf_sticky, ovf_count overflow history; cnt_clr clears both
module imm_narrow8
  import narrow_pkg::*;
#(
  parameter int IN_W  = IN_W_DEFAULT,
  parameter int OUT_W = OUT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    data_in,
  input  logic               sat_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   data_out,
  output logic               ovf,
  output logic               ovf_sticky,
  output logic [COUNT_W-1:0] ovf_count,
  input  logic               cnt_clr
);

  localparam int S1_W = IN_W + 1;
  localparam int S2_W = OUT_W + 1;

  localparam logic [31:0]      SAT_MIN_FULL = sat_min(OUT_W);
  localparam logic [31:0]      SAT_MAX_FULL = sat_max(OUT_W);
  localparam logic [OUT_W-1:0] SAT_MIN      = SAT_MIN_FULL[OUT_W-1:0];
  localparam logic [OUT_W-1:0] SAT_MAX      = SAT_MAX_FULL[OUT_W-1:0];

  logic              s1InReady;
  logic              s1Valid;
  logic [S1_W-1:0]   s1Data;
  logic              s1Sat;
  logic [IN_W-1:0]   s1Word;
  logic              s2InReady;
  logic [S2_W-1:0]   s2Data;
  logic [IN_W-OUT_W:0] topBits;
  logic              fits;
  logic [OUT_W-1:0]  narrowed;
  logic              outXfer;

  // Nothing is accepted while reset is held, even though the slices would be ready.
  assign in_ready = !reset && s1InReady;

  narrow_stage #(.W(S1_W)) stage1 (
    .clk      (clk),
    .reset    (reset),
    .inValid  (in_valid),
    .inReady  (s1InReady),
    .inData   ({sat_en, data_in}),
    .outValid (s1Valid),
    .outReady (s2InReady),
    .outData  (s1Data)
  );

  assign {s1Sat, s1Word} = s1Data;

  // Representable exactly when the bits from the MSB down to the new sign bit agree.
  assign topBits = s1Word[IN_W-1:OUT_W-1];
  assign fits    = (&topBits) || !(|topBits);

  always_comb begin
    narrowed = s1Word[OUT_W-1:0];
    if (!fits && s1Sat == MODE_SAT) begin
      narrowed = s1Word[IN_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

  narrow_stage #(.W(S2_W)) stage2 (
    .clk      (clk),
    .reset    (reset),
    .inValid  (s1Valid),
    .inReady  (s2InReady),
    .inData   ({!fits, narrowed}),
    .outValid (out_valid),
    .outReady (out_ready),
    .outData  (s2Data)
  );

  assign {ovf, data_out} = s2Data;

  assign outXfer = out_valid && out_ready;

  // A clear wins over a coincident counted transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end else if (cnt_clr) begin
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end else if (outXfer && ovf) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != '1) begin
        ovf_count <= ovf_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_narrow8.sv
// tb/tb_imm_narrow8.sv - self-checking bench for imm_narrow8
module tb_imm_narrow8;

  localparam int IW = 8;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] data_in;
  logic          sat_en;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] data_out;
  logic          ovf;
  logic          ovf_sticky;
  logic [7:0]    ovf_count;
  logic          cnt_clr;

  imm_narrow8 #(.IN_W(IW), .OUT_W(OW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .sat_en     (sat_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .ovf        (ovf),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count),
    .cnt_clr    (cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] d;
    logic          o;
    int            age;
  } expT;

  typedef struct {
    logic [IW-1:0] din;
    logic          sat;
    logic [OW-1:0] dout;
    logic          ovf;
  } vecT;

  expT  q[$];
  vecT  vecs[11];
  int   nCmp  = 0;
  int   nFail = 0;
  int   mCount = 0;
  logic mSticky = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: numeric range test and clamp on plain integers.
  function automatic logic [OW:0] refNarrow(input logic [IW-1:0] d, input logic s);
    int v;
    int lo;
    int hi;
    v  = int'($signed(d));
    lo = -(1 << (OW - 1));
    hi = (1 << (OW - 1)) - 1;
    if (v >= lo && v <= hi) return {1'b0, d[OW-1:0]};
    if (s) return (v < 0) ? {1'b1, 4'h8} : {1'b1, 4'h7};
    return {1'b1, d[OW-1:0]};
  endfunction

  // One clock: drive at negedge, sample 1 time unit later, update the model, take the edge.
  task automatic cycle(input logic inV, input logic [IW-1:0] d, input logic s,
                       input logic [OW-1:0] eD, input logic eO,
                       input logic oR, input logic clr, input logic rst,
                       output logic acc);
    logic xo;
    logic frontO;
    expT  e;
    @(negedge clk);
    reset = rst; in_valid = inV; data_in = d; sat_en = s; out_ready = oR; cnt_clr = clr;
    #1;
    acc = 1'b0;
    if (rst) begin
      chk("in_ready_in_reset", 32'(in_ready), 32'(0));
      q.delete();
      mCount  = 0;
      mSticky = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || oR));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0 && q[0].age >= 2));
      chk("ovf_count", 32'(ovf_count), 32'(mCount));
      chk("ovf_sticky", 32'(ovf_sticky), 32'(mSticky));
      acc    = inV && in_ready;
      xo     = out_valid && oR;
      frontO = 1'b0;
      if (xo) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'(1), 32'(0));
        end else begin
          e = q.pop_front();
          frontO = e.o;
          chk("data_out", 32'(data_out), 32'(e.d));
          chk("ovf", 32'(ovf), 32'(e.o));
        end
      end
      if (clr) begin
        mCount  = 0;
        mSticky = 1'b0;
      end else if (xo && frontO) begin
        mSticky = 1'b1;
        if (mCount < 255) mCount++;
      end
      for (int i = 0; i < q.size(); i++) q[i].age++;
      if (acc) begin
        e.d = eD; e.o = eO; e.age = 1;
        q.push_back(e);
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic oR);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0, oR, 1'b0, 1'b0, a);
  endtask

  initial begin
    logic          a;
    logic [OW:0]   r;
    logic [IW-1:0] rd;
    logic          rs;
    int            guard;

    reset = 1'b1; in_valid = 1'b0; data_in = '0; sat_en = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;

    vecs[0]  = '{8'h03, 1'b1, 4'h3, 1'b0};
    vecs[1]  = '{8'hFE, 1'b1, 4'hE, 1'b0};
    vecs[2]  = '{8'hF8, 1'b1, 4'h8, 1'b0};
    vecs[3]  = '{8'h07, 1'b1, 4'h7, 1'b0};
    vecs[4]  = '{8'h08, 1'b1, 4'h7, 1'b1};
    vecs[5]  = '{8'h7F, 1'b1, 4'h7, 1'b1};
    vecs[6]  = '{8'h80, 1'b1, 4'h8, 1'b1};
    vecs[7]  = '{8'hF7, 1'b1, 4'h8, 1'b1};
    vecs[8]  = '{8'h08, 1'b0, 4'h8, 1'b1};
    vecs[9]  = '{8'h80, 1'b0, 4'h0, 1'b1};
    vecs[10] = '{8'h1A, 1'b0, 4'hA, 1'b1};

    // Reset state
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, a);
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, a);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_data_out", 32'(data_out), 32'(0));
    chk("reset_ovf", 32'(ovf), 32'(0));
    chk("reset_count", 32'(ovf_count), 32'(0));
    chk("reset_sticky", 32'(ovf_sticky), 32'(0));

    // Table: pass-through, saturate, wrap
    for (int i = 0; i < 4; i++)
      cycle(1'b1, vecs[i].din, vecs[i].sat, vecs[i].dout, vecs[i].ovf, 1'b1, 1'b0, 1'b0, a);
    idle(3, 1'b1);
    #1;
    chk("count_after_passthrough", 32'(ovf_count), 32'(0));
    for (int i = 4; i < 11; i++)
      cycle(1'b1, vecs[i].din, vecs[i].sat, vecs[i].dout, vecs[i].ovf, 1'b1, 1'b0, 1'b0, a);
    idle(3, 1'b1);
    #1;
    chk("count_after_table", 32'(ovf_count), 32'(7));
    chk("sticky_after_table", 32'(ovf_sticky), 32'(1));

    // Backpressure: two accepted, third refused, then accepted on release
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, a);
    cycle(1'b1, 8'h01, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, a);
    chk("bp_acc1", 32'(a), 32'(1));
    cycle(1'b1, 8'h02, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, a);
    chk("bp_acc2", 32'(a), 32'(1));
    cycle(1'b1, 8'h03, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, a);
    chk("bp_third_refused", 32'(a), 32'(0));
    cycle(1'b1, 8'h03, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, a);
    chk("bp_release_accept", 32'(a), 32'(1));
    idle(3, 1'b1);
    chk("bp_drained", 32'(q.size()), 32'(0));

    // Counter saturation: 300 overflow words back to back
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'h40, 1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, a);
    idle(3, 1'b1);
    #1;
    chk("count_saturated", 32'(ovf_count), 32'(255));

    // cnt_clr coinciding with a counted transfer
    cycle(1'b1, 8'hC0, 1'b1, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, a);
    idle(2, 1'b0);
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, a);
    #1;
    chk("clr_priority_count", 32'(ovf_count), 32'(0));
    chk("clr_priority_sticky", 32'(ovf_sticky), 32'(0));

    // Mid-stream reset with both stages full and stalled
    cycle(1'b1, 8'h20, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b1, 8'h02, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, a);
    idle(2, 1'b0);
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, a);
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'(0));
    chk("midreset_count", 32'(ovf_count), 32'(0));
    cycle(1'b1, 8'h05, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, a);
    chk("midreset_accept", 32'(a), 32'(1));
    idle(3, 1'b1);

    // Randomized traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      rd = IW'($urandom);
      rs = 1'($urandom);
      r  = refNarrow(rd, rs);
      cycle(($urandom_range(0, 3) != 0), rd, rs, r[OW-1:0], r[OW],
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 399) == 0), a);
    end

    // Bounded drain
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      idle(1, 1'b1);
      guard++;
    end
    chk("final_drain", 32'(q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/imm_narrow8.md
# imm_narrow8

Pipelined signed-narrowing unit: the inverse of the CPU's 4→8-bit sign extender. It accepts IN_W-bit two's-complement values on a valid/ready stream and returns OUT_W-bit results, either saturated or wrapped. It flags every value that is not exactly representable in OUT_W bits and keeps a sticky flag and a saturating count of those overflows. It sits on the writeback/store path wherever an 8-bit datapath value is packed back into a 4-bit immediate or register field.

## Interface
- IN_W, 8, input word width
- OUT_W, 4, output word width; must satisfy 2 ≤ OUT_W < IN_W
- clk  input  1  sole clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk
- in_valid  input  1  upstream has a word on data_in
- in_ready  output  1  unit can accept a word this cycle
- data_in  input  IN_W  signed source value
- sat_en  input  1  travels with data_in: 1 = saturate, 0 = wrap (truncate)
- out_valid  output  1  data_out and ovf are valid
- out_ready  input  1  downstream accepts the output word
- data_out  output  OUT_W  narrowed result
- ovf  output  1  data_in was not representable in OUT_W bits
- ovf_sticky  output  1  set by any delivered overflow; cleared only by reset or cnt_clr
- ovf_count  output  8  count of delivered overflow words; saturates at 255
- cnt_clr  input  1  single-cycle pulse that clears ovf_count and ovf_sticky

## Operation
- **Representable test:** fits = 1 when data_in[IN_W-1:OUT_W-1] are all equal. ovf = !fits.
- **When fits = 1:** data_out = data_in[OUT_W-1:0], independent of mode.
- **Overflow, sat_en = 1:**
  - data_in negative (MSB = 1): data_out = {1, 0…0}, which is 4'h8 at defaults.
  - data_in positive: data_out = {0, 1…1}, which is 4'h7 at defaults.
- **Overflow, sat_en = 0:** data_out = data_in[OUT_W-1:0].
- **Pipeline:** two register stages.
  - S1 captures data_in and sat_en, and computes fits.
  - S2 holds the final data_out and ovf.
  - Each stage has its own valid bit.
- **Handshake rules:**
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - S2 loads when it is empty or out_ready = 1.
  - S1 advances when S2 loads.
  - in_ready = !s1_valid || S2 loads. This is combinational and permits 1 word/cycle.
  - out_valid stays asserted, and data_out/ovf stay stable, until the word is accepted.
  - Words are never dropped, duplicated or reordered.
  - data_in and sat_en are ignored when in_valid = 0.
- **Counters:**
  - On an output transfer with ovf = 1: ovf_count increments unless it is already 255 (it holds at 255, no wrap), and ovf_sticky is set.
  - cnt_clr has priority. If it coincides with a counted transfer, the result is ovf_count = 0 and ovf_sticky = 0.
- **Reset:**
  - All valid bits, data_out, ovf, ovf_sticky and ovf_count go to 0.
  - Words in flight are discarded. Downstream must tolerate a word vanishing mid-stall.
  - In the first cycle after reset deasserts, in_ready = 1.
  - While reset = 1, in_ready = 0 and no transfer is counted.

## Timing
- **Latency:** a word accepted at edge N is presented at out_valid right after edge N+1 and transfers at edge N+2 when out_ready = 1.
- **Throughput:** 1 word/cycle when out_ready is held at 1.
- **Stall capacity:** with out_ready = 0, exactly 2 words are accepted; in_ready then drops combinationally.
- **Leaving a stall:** when out_ready rises while full, in_ready rises in the same cycle. A new word enters while S2 drains, with no bubble.
- ovf_count and ovf_sticky update on the edge of the counted transfer, so they are visible the following cycle.

## Structure
- Shared package `narrow_pkg`:
  - default IN_W/OUT_W
  - mode constants MODE_WRAP = 0, MODE_SAT = 1
  - function sat_min(OUT_W) / sat_max(OUT_W)
  - COUNT_W = 8
- One sub-module, `narrow_stage`: a generic valid/ready register slice, parameterized by payload width and instantiated twice (S1 and S2).
- The fits/saturate logic and the counters live in `imm_narrow8`.

## Test plan
- **Pass-through:** sat_en = 1, stream 8'h03, 8'hFE, 8'hF8, 8'h07 with out_ready = 1 → data_out 3, E, 8, 7; ovf = 0 on all; outputs appear 2 cycles after each accept; ovf_count = 0.
- **Saturate:** sat_en = 1, inputs 8'h08, 8'h7F, 8'h80, 8'hF7 → data_out 7, 7, 8, 8; ovf = 1 on all; ovf_count = 4; ovf_sticky = 1.
- **Wrap:** sat_en = 0, inputs 8'h08, 8'h80, 8'h1A → data_out 8, 0, A; ovf = 1, 1, 1.
- **Backpressure:**
  - Hold out_ready = 0 and offer 8'h01, 8'h02, 8'h03 → only 2 accepted, in_ready = 0 on the third.
  - Release out_ready → outputs 1, 2, 3 in order; 8'h03 is accepted in the release cycle.
- **Counter limits:**
  - 300 back-to-back overflow words → ovf_count = 255 (no wrap).
  - cnt_clr asserted in the same cycle as an overflow transfer → ovf_count = 0, ovf_sticky = 0.
- **Mid-stream reset:** assert reset for 1 cycle while both stages are full and stalled → out_valid = 0, ovf_count = 0 after the edge; in_ready = 1 the next cycle; a new word 8'h05 emerges as 4'h5 two cycles after acceptance.
